// File: rtl/booth_seq_mul.sv
// Sequential radix-2 Booth multiplier.
// Operands are widened to WIDTH+1 bits (sign- or zero-extended by mode), so
// every operation is a signed (WIDTH+1)x(WIDTH+1) Booth multiply that takes
// exactly WIDTH+1 add/shift iterations, one per clock.
module booth_seq_mul #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 2)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     M,
    input  logic [WIDTH-1:0]     P,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   op
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    // Accumulator carries one guard bit above the WIDTH+1 operand width so
    // that subtracting the most negative extended multiplicand cannot wrap.
    logic [WIDTH+1:0] acc;
    logic [WIDTH:0]   q;
    logic             q_1;
    logic [WIDTH:0]   mreg;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH+1:0]   m_sext;
    logic [WIDTH+1:0]   sum;
    logic [WIDTH+1:0]   acc_shift;
    logic [WIDTH:0]     q_shift;
    logic               last;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH:0]     m_ext;
    logic [WIDTH:0]     p_ext;

    assign m_sext = {mreg[WIDTH], mreg};
    assign last   = (cnt == CNT_W'(1));

    // Operand widening at acceptance: mode decides sign vs zero extension.
    assign m_ext = is_signed ? {M[WIDTH-1], M} : {1'b0, M};
    assign p_ext = is_signed ? {P[WIDTH-1], P} : {1'b0, P};

    // Booth recode of {Q[0], q_1}: add, subtract or pass the multiplicand.
    always_comb begin
        sum = acc;
        case ({q[0], q_1})
            2'b01:   sum = acc + m_sext;
            2'b10:   sum = acc - m_sext;
            default: sum = acc;
        endcase
    end

    // Arithmetic right shift of {A,Q,q_1}; q_1 picks up the old Q[0].
    assign acc_shift = {sum[WIDTH+1], sum[WIDTH+1:1]};
    assign q_shift   = {sum[0], q[WIDTH:1]};

    // The low 2*WIDTH bits of {A,Q} after the final shift are the product;
    // the exact result always fits there in both modes.
    assign product = {acc_shift[WIDTH-2:0], q_shift};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic: start only matters in IDLE, DONE lasts one cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Registered status outputs, decoded from the next state so they line
    // up with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_next == RUN);
            done <= (state_next == DONE);
        end
    end

    // Datapath: load on acceptance, iterate in RUN, capture result on the
    // final iteration. op is otherwise held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc  <= '0;
            q    <= '0;
            q_1  <= 1'b0;
            mreg <= '0;
            cnt  <= '0;
            op   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mreg <= m_ext;
                        q    <= p_ext;
                        acc  <= '0;
                        q_1  <= 1'b0;
                        cnt  <= CNT_W'(WIDTH + 1);
                    end
                end
                RUN: begin
                    acc <= acc_shift;
                    q   <= q_shift;
                    q_1 <= q[0];
                    cnt <= cnt - CNT_W'(1);
                    if (last) op <= product;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_seq_mul.sv
// Self-checking bench for booth_seq_mul: directed vectors, handshake and
// latency, start-while-busy, asynchronous reset, and a randomised sweep
// against a plain integer multiply.
module tb_booth_seq_mul;

    localparam int W = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic             is_signed;
    logic [W-1:0]     M;
    logic [W-1:0]     P;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   op;

    int checks = 0;
    int errors = 0;

    booth_seq_mul #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .M         (M),
        .P         (P),
        .busy      (busy),
        .done      (done),
        .op        (op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: extend each operand by mode into a 64-bit integer,
    // multiply, keep the low 2*W bits.
    function automatic logic [2*W-1:0] ref_mul(input logic s, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        longint x, y, r;
        if (s) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({1'b0, a});
            y = longint'({1'b0, b});
        end
        r = x * y;
        return r[2*W-1:0];
    endfunction

    // Issue one operation and follow it to completion.
    // lat   : clocks from the start edge to the sample where done is seen
    // bcnt  : cycles busy was observed high
    // dcnt  : cycles done was observed high (done cycle plus the one after)
    // opmid : op value seen in the first cycle after acceptance
    task automatic run_op(input logic s, input logic [W-1:0] m, input logic [W-1:0] p,
                          output logic [2*W-1:0] res, output int lat,
                          output int bcnt, output int dcnt,
                          output logic [2*W-1:0] opmid);
        @(negedge clk);
        is_signed = s;
        M         = m;
        P         = p;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        opmid = op;
        lat   = 0;
        bcnt  = busy ? 1 : 0;
        dcnt  = 0;
        while (!done && lat < 4 * W) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) bcnt++;
        end
        res = op;
        if (done) dcnt = 1;
        @(posedge clk);
        #1;
        if (done) dcnt++;
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        M         = '0;
        P         = '0;
        #12;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || op !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b op=%h, required 0 0 0", busy, done, op);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed;
        logic             s_t [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [W-1:0]     m_t [7] = '{8'hFE, 8'h06, 8'hFF, 8'hFF, 8'h80, 8'h80, 8'h00};
        logic [W-1:0]     p_t [7] = '{8'h05, 8'h07, 8'hFF, 8'hFF, 8'h80, 8'h7F, 8'h80};
        logic [2*W-1:0]   e_t [7] = '{16'hFFF6, 16'h002A, 16'hFE01, 16'h0001,
                                      16'h4000, 16'hC080, 16'h0000};
        logic [2*W-1:0]   res, opmid;
        int               lat, bcnt, dcnt;
        for (int i = 0; i < 7; i++) begin
            run_op(s_t[i], m_t[i], p_t[i], res, lat, bcnt, dcnt, opmid);
            checks++;
            if (res !== e_t[i]) begin
                errors++;
                $display("FAIL directed_op[%0d]: op=%h, required %h", i, res, e_t[i]);
            end
            checks++;
            if (lat !== W + 1 || bcnt !== W + 1 || dcnt !== 1) begin
                errors++;
                $display("FAIL directed_timing[%0d]: lat=%0d busy=%0d done=%0d, required %0d %0d 1",
                         i, lat, bcnt, dcnt, W + 1, W + 1);
            end
        end
    endtask

    task automatic test_start_ignored;
        int             c;
        int             extra;
        logic [2*W-1:0] res, opmid;
        int             lat, bcnt, dcnt;
        @(negedge clk);
        is_signed = 1'b0;
        M         = 8'd3;
        P         = 8'd4;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        c = 0;
        while (!done && c < 4 * W) begin
            @(posedge clk);
            #1;
            c++;
            if (c == 2) begin
                start = 1'b1;
                M     = 8'd9;
                P     = 8'd9;
            end
        end
        checks++;
        if (c !== W + 1 || op !== 16'h000C) begin
            errors++;
            $display("FAIL start_ignored_first: lat=%0d op=%h, required %0d 000c", c, op, W + 1);
        end
        // start is still high across the DONE cycle and must be ignored
        @(posedge clk);
        #1;
        start = 1'b0;
        extra = 0;
        for (int i = 0; i < 2 * W; i++) begin
            if (done || busy) extra++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (extra !== 0 || op !== 16'h000C) begin
            errors++;
            $display("FAIL start_ignored_queue: active_cycles=%0d op=%h, required 0 000c", extra, op);
        end
        run_op(1'b0, 8'd9, 8'd9, res, lat, bcnt, dcnt, opmid);
        checks++;
        if (res !== 16'h0051 || lat !== W + 1 || opmid !== 16'h000C) begin
            errors++;
            $display("FAIL start_after_idle: op=%h lat=%0d opmid=%h, required 0051 %0d 000c",
                     res, lat, opmid, W + 1);
        end
    endtask

    task automatic test_async_reset;
        int             dseen;
        logic [2*W-1:0] res, opmid;
        int             lat, bcnt, dcnt;
        @(negedge clk);
        is_signed = 1'b1;
        M         = 8'h11;
        P         = 8'h22;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || op !== '0) begin
            errors++;
            $display("FAIL async_reset: busy=%b done=%b op=%h, required 0 0 0", busy, done, op);
        end
        dseen = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (done || busy) dseen++;
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2 * W; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) dseen++;
        end
        checks++;
        if (dseen !== 0 || op !== '0) begin
            errors++;
            $display("FAIL reset_abort: active_cycles=%0d op=%h, required 0 0000", dseen, op);
        end
        run_op(1'b1, 8'hFF, 8'hFF, res, lat, bcnt, dcnt, opmid);
        checks++;
        if (res !== 16'h0001 || lat !== W + 1 || dcnt !== 1) begin
            errors++;
            $display("FAIL after_reset: op=%h lat=%0d done=%0d, required 0001 %0d 1",
                     res, lat, dcnt, W + 1);
        end
    endtask

    task automatic test_random;
        logic [2*W-1:0] res, opmid, expv, prev;
        logic           s;
        logic [W-1:0]   m, p;
        int             lat, bcnt, dcnt;
        prev = op;
        for (int i = 0; i < 2000; i++) begin
            s = 1'($urandom_range(0, 1));
            m = W'($urandom);
            p = W'($urandom);
            case ($urandom_range(0, 9))
                0: m = {1'b1, {(W-1){1'b0}}};
                1: p = {W{1'b1}};
                2: m = '0;
                default: ;
            endcase
            expv = ref_mul(s, m, p);
            run_op(s, m, p, res, lat, bcnt, dcnt, opmid);
            checks++;
            if (res !== expv || lat !== W + 1 || dcnt !== 1) begin
                errors++;
                $display("FAIL random[%0d] s=%b m=%h p=%h: op=%h lat=%0d done=%0d, required %h %0d 1",
                         i, s, m, p, res, lat, dcnt, expv, W + 1);
            end
            checks++;
            if (opmid !== prev || op !== expv) begin
                errors++;
                $display("FAIL random_hold[%0d]: op_during_run=%h op_after=%h, required %h %h",
                         i, opmid, op, prev, expv);
            end
            prev = expv;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_ignored();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/booth_seq_mul.md
Name: booth_seq_mul

Overview:
- Parametrised, sequential radix-2 Booth multiplier. Successor to the fixed 4-bit combinational Booth multiplier.
- Adds a configurable operand width, a runtime signed/unsigned mode, a start/done handshake and a fixed-latency iterative datapath of one add/shift per clock.
- Sits as a shared arithmetic unit behind a simple request/complete interface in the lab datapath.

Parameters:
- WIDTH, 8, operand width in bits (≥2); product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH+2), iteration counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
- M  input  WIDTH  multiplicand; sampled with start
- P  input  WIDTH  multiplier; sampled with start
- busy  output  1  high while an operation is in progress (RUN state)
- done  output  1  single-cycle completion pulse
- op  output  2*WIDTH  product; valid when done=1, held until next completion

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, op=0; all internal registers cleared. Reset mid-operation aborts with no done pulse. After rst deasserts, the block accepts start on the first edge.
- Operand extension on acceptance: M and P are extended to WIDTH+1 bits, sign-extended if is_signed=1, zero-extended otherwise. Every operation therefore runs as a signed (WIDTH+1)x(WIDTH+1) Booth multiply.
- Registers:
  - A (accumulator), WIDTH+2 bits. The extra guard bit prevents overflow when subtracting the most negative multiplicand.
  - Q (multiplier), WIDTH+1 bits.
  - q_1 (Booth bit), 1 bit.
  - Mreg, WIDTH+1 bits.
  - cnt, CNT_W bits.
- FSM IDLE -> RUN -> DONE -> IDLE.
  - IDLE: busy=0, done=0. On an edge with start=1: load Mreg and Q, A=0, q_1=0, cnt=WIDTH+1; go to RUN. With start=0, remain in IDLE.
  - RUN: busy=1. On each edge, select from {Q[0], q_1}:
    - 01: A += sext(Mreg)
    - 10: A -= sext(Mreg)
    - 00 / 11: no change
  - Then arithmetic right shift of {A,Q,q_1} by one, and cnt -= 1. The edge on which cnt goes 1 -> 0 performs the final iteration, writes op = lower 2*WIDTH bits of the resulting {A,Q}, sets done=1, and goes to DONE.
  - DONE: busy=0, done=1 for exactly this one cycle; start is ignored. The next edge goes to IDLE and done drops to 0.
- Latency: start sampled at edge k gives done=1 in the cycle following edge k+WIDTH+1 (WIDTH+1 clocks). busy is high from edge k to edge k+WIDTH+1. Latency is independent of operand values and mode.
- Minimum issue interval: WIDTH+3 clocks (RUN + DONE + IDLE sample).
- start in RUN or DONE is ignored (not queued). Operand and mode changes during RUN have no effect.
- op changes only on the completion edge; it holds its value through IDLE and the next operation until that operation completes.
- Result is exact for all operand pairs in both modes. The product always fits in 2*WIDTH bits, e.g. signed (-2^(W-1))^2 = 2^(2W-2) and unsigned (2^W-1)^2.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- WIDTH=8, is_signed=1, M=8'hFE (-2), P=8'h05 -> done after 9 clocks, op=16'hFFF6 (-10); busy high for exactly 9 cycles; done high for exactly 1 cycle.
- is_signed=0, M=8'd6, P=8'd7 -> op=16'h002A. Then M=P=8'hFF -> op=16'hFE01 (65025). Same bits with is_signed=1 -> op=16'h0001.
- is_signed=1, M=P=8'h80 -> op=16'h4000. M=8'h80, P=8'h7F -> op=16'hC080 (-16256). M=8'h00, P=8'h80 -> op=16'h0000.
- Start at edge k (M=3, P=4), pulse start again at k+3 with M=9, P=9, and hold start high through DONE -> exactly one done, op=16'h000C. A new op is accepted only from IDLE, and its done arrives 9 clocks after its start edge.
- Assert rst asynchronously (mid-cycle) during RUN -> busy, done and op go to 0 immediately with no done pulse. Release rst, then start with M=-1, P=-1 signed -> op=16'h0001.
- Randomised sweep (≥2000 pairs, both modes, also WIDTH=4 and WIDTH=16 builds) checked against a reference multiply -> all match, op stable between completions.
